// File: rtl/sipo_load_pkg.sv
// Shared types and default sizing for the sipo_load frame assembler.
// Stands in for the shared parameters.vh: PE_NUM, DATA_WIDTH and derived WORD_W.
`ifndef PE_NUM
`define PE_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef WORD_W
`define WORD_W (2*`DATA_WIDTH)
`endif

package sipo_load_pkg;
  localparam int DEF_PE_NUM     = `PE_NUM;
  localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
  localparam int DEF_WORD_W     = `WORD_W;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/sipo_lane_reg.sv
// Multi-lane register with a single lane-indexed write port.
module sipo_lane_reg #(
  parameter int LANES = 4,
  parameter int W     = 32,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [IDX_W-1:0]          idx,
  input  logic [W-1:0]              d,
  output logic [LANES-1:0][W-1:0]   q
);

  logic [LANES-1:0][W-1:0] q_nxt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign q_nxt[k] = (we && idx == IDX_W'(k)) ? d : q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/sipo_load.sv
// Serial-in parallel-out frame assembler: PE_NUM words -> one frame, lane 0 first.
// Define SIPO_DBUF_EN for a separate output register (double buffering).
module sipo_load
  import sipo_load_pkg::*;
#(
  parameter int PE_NUM     = DEF_PE_NUM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             s_in_v,
  input  logic [2*DATA_WIDTH-1:0]          s_in,
  output logic                             s_in_rdy,
  output logic                             p_out_v,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]   p_out,
  input  logic                             p_out_rdy
);

  localparam int WORD_W = 2*DATA_WIDTH;
  localparam int CNT_W  = $clog2(PE_NUM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PE_NUM-1);

  logic [CNT_W-1:0]              cnt;
  logic [PE_NUM-1:0][WORD_W-1:0] acc_q;
  logic                          in_xfer, out_xfer, last, wr, commit;

  assign in_xfer  = s_in_v && s_in_rdy;
  assign out_xfer = p_out_v && p_out_rdy;
  assign last     = (cnt == LAST);
  // clr beats a coincident input word
  assign wr       = in_xfer && !clr;
  assign commit   = wr && last;

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (wr)     cnt <= last ? '0 : cnt + 1'b1;
  end

  sipo_lane_reg #(.LANES(PE_NUM), .W(WORD_W), .IDX_W(CNT_W)) u_acc (
    .clk (clk),
    .rst (rst),
    .we  (wr),
    .idx (cnt),
    .d   (s_in),
    .q   (acc_q)
  );

`ifdef SIPO_DBUF_EN
  logic [PE_NUM-1:0][WORD_W-1:0] out_q, frame;
  logic                          out_v;

  // Commit happens on the last lane's write edge, so merge the incoming word.
  always_comb begin
    frame           = acc_q;
    frame[PE_NUM-1] = s_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v <= 1'b0;
      out_q <= '0;
    end else if (commit) begin
      out_v <= 1'b1;
      out_q <= frame;
    end else if (out_xfer) begin
      out_v <= 1'b0;
    end
  end

  always_comb begin
    s_in_rdy = !(last && out_v && !p_out_rdy);
    p_out_v  = out_v;
  end

  assign p_out = out_q;
`else
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (commit)    state_nxt = FULL;
      FULL:    if (p_out_rdy) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    s_in_rdy = (state == FILL);
    p_out_v  = (state == FULL);
  end

  // The accumulator is the output register; hide it while it is still filling.
  assign p_out = p_out_v ? acc_q : '0;
`endif

endmodule

// File: tb/tb_sipo_load.sv
// Self-checking bench for sipo_load: directed cases plus randomized traffic
// against a word-list/frame-queue reference model. Adapts to SIPO_DBUF_EN.
module tb_sipo_load;
  import sipo_load_pkg::*;

  localparam int PE_NUM = DEF_PE_NUM;
  localparam int DW     = DEF_DATA_WIDTH;
  localparam int WW     = 2*DW;
  localparam int FW     = PE_NUM*WW;

  logic          clk, rst, clr, s_in_v, s_in_rdy, p_out_v, p_out_rdy;
  logic [WW-1:0] s_in;
  logic [FW-1:0] p_out;

  int total = 0;
  int bad   = 0;

  sipo_load #(.PE_NUM(PE_NUM), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .s_in_v    (s_in_v),
    .s_in      (s_in),
    .s_in_rdy  (s_in_rdy),
    .p_out_v   (p_out_v),
    .p_out     (p_out),
    .p_out_rdy (p_out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted words accumulate in a list; every PE_NUM of
  // them form a frame that must appear on the output, in order.
  logic [WW-1:0] part[$];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] held_p, f;
  logic          held;
  int            words_in  = 0;
  int            frames_out = 0;
  logic          exp_rdy;

  initial held = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      part.delete();
      exp_q.delete();
      held = 1'b0;
    end else begin
      chk("p_out_v", p_out_v, exp_q.size() > 0);
`ifdef SIPO_DBUF_EN
      exp_rdy = !(part.size() == PE_NUM-1 && exp_q.size() > 0 && !p_out_rdy);
`else
      exp_rdy = (exp_q.size() == 0);
`endif
      chk("s_in_rdy", s_in_rdy, exp_rdy);
      if (held) chk("hold_stable", p_out, held_p);
      if (p_out_v && p_out_rdy) begin
        frames_out++;
        if (exp_q.size() == 0) chk("extra_frame", 1'b1, 1'b0);
        else chk("frame", p_out, exp_q.pop_front());
      end
      held   = p_out_v && !p_out_rdy;
      held_p = p_out;
      if (clr) part.delete();
      else if (s_in_v && s_in_rdy) begin
        words_in++;
        part.push_back(s_in);
        if (part.size() == PE_NUM) begin
          for (int k = 0; k < PE_NUM; k++) f[k*WW +: WW] = part[k];
          exp_q.push_back(f);
          part.delete();
        end
      end
    end
  end

  task automatic send(input logic [WW-1:0] w, output int cycles);
    logic ok;
    cycles = 0;
    s_in_v = 1'b1;
    s_in   = w;
    do begin
      @(negedge clk);
      ok = s_in_rdy;
      @(posedge clk); #1;
      cycles++;
    end while (!ok && cycles < 200);
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
    s_in_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || p_out_v) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_p_out_v", p_out_v, 1'b0);
    chk("rst_p_out", p_out, '0);
    chk("rst_s_in_rdy", s_in_rdy, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, rdy_end, exp_acc, f0, w0, cyc;
    logic [FW-1:0] fr;
    rst = 1'b1; clr = 1'b0; s_in_v = 1'b0; s_in = '0; p_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_p_out_v", p_out_v, 1'b0);
    chk("reset_p_out", p_out, '0);
    chk("reset_s_in_rdy", s_in_rdy, 1'b1);
    @(posedge clk); #1;

    // basic frame, one-cycle valid
    for (int i = 1; i <= 4; i++) send({8{4'(i)}}, n);
    @(negedge clk);
    chk("basic_v", p_out_v, 1'b1);
    fr = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    chk("basic_frame", p_out, fr);
    @(negedge clk);
    chk("basic_v_drop", p_out_v, 1'b0);
    @(posedge clk); #1;

    // backpressure
    p_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(WW'(32'h100 + i), n);
    fr = {32'h103, 32'h102, 32'h101, 32'h100};
    s_in_v = 1'b1; s_in = 32'h200; acc = 0; rdy_end = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_v", p_out_v, 1'b1);
      chk("bp_frame", p_out, fr);
      rdy_end = s_in_rdy;
      if (s_in_rdy) acc++;
      @(posedge clk); #1;
      if (rdy_end) s_in = s_in + 1'b1;
    end
    s_in_v = 1'b0;
`ifdef SIPO_DBUF_EN
    exp_acc = 3;
`else
    exp_acc = 0;
`endif
    chk("bp_accepted", acc, exp_acc);
    chk("bp_rdy_low", rdy_end, 0);
    p_out_rdy = 1'b1;
`ifdef SIPO_DBUF_EN
    send(32'h203, n);
`endif
    drain();

`ifdef SIPO_DBUF_EN
    // streaming at one word per cycle
    f0 = frames_out; cyc = 0;
    for (int i = 0; i < 16; i++) begin
      send(WW'($urandom), n);
      cyc += n;
    end
    drain();
    chk("stream_cycles", cyc, 16);
    chk("stream_frames", frames_out - f0, 4);
`endif

    // clr drops a partial frame and beats a coincident word
    send(32'hA, n); send(32'hB, n);
    clr = 1'b1; s_in_v = 1'b1; s_in = 32'hC;
    @(posedge clk); #1;
    clr = 1'b0; s_in_v = 1'b0;
    for (int i = 1; i <= 4; i++) send(WW'(i), n);
    @(negedge clk);
    chk("clr_frame", p_out, {32'h4, 32'h3, 32'h2, 32'h1});
    @(posedge clk); #1;
    drain();

    // reset mid-frame and while a frame is held
    for (int i = 0; i < 3; i++) send(WW'(32'h300 + i), n);
    pulse_rst();
    for (int i = 5; i <= 8; i++) send(WW'(i), n);
    @(negedge clk);
    chk("post_rst_frame", p_out, {32'h8, 32'h7, 32'h6, 32'h5});
    @(posedge clk); #1;
    drain();
    p_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(WW'(32'h400 + i), n);
    @(posedge clk); #1;
    pulse_rst();
    p_out_rdy = 1'b1;
    for (int i = 9; i <= 12; i++) send(WW'(i), n);
    @(negedge clk);
    chk("held_rst_frame", p_out, {32'hC, 32'hB, 32'hA, 32'h9});
    @(posedge clk); #1;
    drain();

    // randomized gaps, 100 frames
    f0 = frames_out; w0 = words_in; cyc = 0;
    while (words_in - w0 < 100*PE_NUM && cyc < 20000) begin
      s_in_v    = ($urandom_range(0, 3) != 0);
      s_in      = WW'($urandom);
      p_out_rdy = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    s_in_v = 1'b0;
    p_out_rdy = 1'b1;
    drain();
    chk("rand_words", words_in - w0, 100*PE_NUM);
    chk("rand_frames", frames_out - f0, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
